// File: rtl/compute_memory.sv
// Read-only ROM of the 64 SHA-256 round constants K[0..63].
// Registered output with one-cycle read latency; cleared asynchronously by reset.
module compute_memory (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  addr,
    output logic [31:0] k_out
);

    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] k_d;
    logic [DATA_W-1:0] k_q;

    // Constant decode; X/Z addresses fall through to zero.
    always_comb begin
        k_d = '0;
        case (addr)
            6'd0:  k_d = 32'h428a2f98;
            6'd1:  k_d = 32'h71374491;
            6'd2:  k_d = 32'hb5c0fbcf;
            6'd3:  k_d = 32'he9b5dba5;
            6'd4:  k_d = 32'h3956c25b;
            6'd5:  k_d = 32'h59f111f1;
            6'd6:  k_d = 32'h923f82a4;
            6'd7:  k_d = 32'hab1c5ed5;
            6'd8:  k_d = 32'hd807aa98;
            6'd9:  k_d = 32'h12835b01;
            6'd10: k_d = 32'h243185be;
            6'd11: k_d = 32'h550c7dc3;
            6'd12: k_d = 32'h72be5d74;
            6'd13: k_d = 32'h80deb1fe;
            6'd14: k_d = 32'h9bdc06a7;
            6'd15: k_d = 32'hc19bf174;
            6'd16: k_d = 32'he49b69c1;
            6'd17: k_d = 32'hefbe4786;
            6'd18: k_d = 32'h0fc19dc6;
            6'd19: k_d = 32'h240ca1cc;
            6'd20: k_d = 32'h2de92c6f;
            6'd21: k_d = 32'h4a7484aa;
            6'd22: k_d = 32'h5cb0a9dc;
            6'd23: k_d = 32'h76f988da;
            6'd24: k_d = 32'h983e5152;
            6'd25: k_d = 32'ha831c66d;
            6'd26: k_d = 32'hb00327c8;
            6'd27: k_d = 32'hbf597fc7;
            6'd28: k_d = 32'hc6e00bf3;
            6'd29: k_d = 32'hd5a79147;
            6'd30: k_d = 32'h06ca6351;
            6'd31: k_d = 32'h14292967;
            6'd32: k_d = 32'h27b70a85;
            6'd33: k_d = 32'h2e1b2138;
            6'd34: k_d = 32'h4d2c6dfc;
            6'd35: k_d = 32'h53380d13;
            6'd36: k_d = 32'h650a7354;
            6'd37: k_d = 32'h766a0abb;
            6'd38: k_d = 32'h81c2c92e;
            6'd39: k_d = 32'h92722c85;
            6'd40: k_d = 32'ha2bfe8a1;
            6'd41: k_d = 32'ha81a664b;
            6'd42: k_d = 32'hc24b8b70;
            6'd43: k_d = 32'hc76c51a3;
            6'd44: k_d = 32'hd192e819;
            6'd45: k_d = 32'hd6990624;
            6'd46: k_d = 32'hf40e3585;
            6'd47: k_d = 32'h106aa070;
            6'd48: k_d = 32'h19a4c116;
            6'd49: k_d = 32'h1e376c08;
            6'd50: k_d = 32'h2748774c;
            6'd51: k_d = 32'h34b0bcb5;
            6'd52: k_d = 32'h391c0cb3;
            6'd53: k_d = 32'h4ed8aa4a;
            6'd54: k_d = 32'h5b9cca4f;
            6'd55: k_d = 32'h682e6ff3;
            6'd56: k_d = 32'h748f82ee;
            6'd57: k_d = 32'h78a5636f;
            6'd58: k_d = 32'h84c87814;
            6'd59: k_d = 32'h8cc70208;
            6'd60: k_d = 32'h90befffa;
            6'd61: k_d = 32'ha4506ceb;
            6'd62: k_d = 32'hbef9a3f7;
            6'd63: k_d = 32'hc67178f2;
            default: k_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k_out = k_q;

endmodule

// File: tb/tb_compute_memory.sv
// Scoreboard bench for compute_memory: expected constants are queued when addr is
// driven and popped when the registered output is sampled after the edge.
module tb_compute_memory;

    logic        clk;
    logic        reset;
    logic [5:0]  addr;
    logic [31:0] k_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    compute_memory dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .k_out (k_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive addr at the falling edge, queue its constant, land 1 ns after the rising edge.
    task automatic drive(input logic [5:0] a);
        @(negedge clk);
        addr = a;
        exp_q.push_back(k_tab[a]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(6'd0);
        checks++;
        exp_v = exp_q.pop_front();
        if (k_out !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_read: got %08h expected %08h", k_out, exp_v);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (k_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got %08h expected 00000000", k_out);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (k_out !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %08h expected 00000000", i, k_out);
            end
        end
        @(negedge clk);
        addr = 6'd7;
        reset = 1'b0;
        #2;
        checks++;
        if (k_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_before_edge: got %08h expected 00000000", k_out);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 64; i++) begin
            drive(6'(i));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sweep addr %0d: scoreboard empty, got %08h", i, k_out);
            end else begin
                exp_v = exp_q.pop_front();
                if (k_out !== exp_v) begin
                    errors++;
                    $display("FAIL sweep addr %0d: got %08h expected %08h", i, k_out, exp_v);
                end
            end
        end
    endtask

    task automatic test_latency();
        drive(6'd5);
        checks++;
        exp_v = exp_q.pop_front();
        if (k_out !== exp_v) begin
            errors++;
            $display("FAIL latency_setup: got %08h expected %08h", k_out, exp_v);
        end
        #7;
        addr = 6'd47;
        exp_q.push_back(k_tab[47]);
        #1;
        checks++;
        if (k_out !== 32'h59f111f1) begin
            errors++;
            $display("FAIL latency_before_edge: got %08h expected 59f111f1", k_out);
        end
        @(posedge clk);
        #1;
        checks++;
        exp_v = exp_q.pop_front();
        if (k_out !== exp_v) begin
            errors++;
            $display("FAIL latency_after_edge: got %08h expected %08h", k_out, exp_v);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) begin
            drive(6'd18);
            checks++;
            exp_v = exp_q.pop_front();
            if (k_out !== exp_v) begin
                errors++;
                $display("FAIL hold cycle %0d: got %08h expected %08h", i, k_out, exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        drive(6'd63);
        drive(6'd0);
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_queue: got %0d entries expected 2", exp_q.size());
        end else begin
            exp_v = exp_q.pop_front();
            if (exp_v !== 32'hc67178f2) begin
                errors++;
                $display("FAIL wrap_table: got %08h expected c67178f2", exp_v);
            end
            exp_v = exp_q.pop_front();
            if (k_out !== exp_v) begin
                errors++;
                $display("FAIL wrap_to_zero: got %08h expected %08h", k_out, exp_v);
            end
        end
        // Back-to-back 63 -> 0 observed edge by edge.
        drive(6'd63);
        checks++;
        exp_v = exp_q.pop_front();
        if (k_out !== exp_v) begin
            errors++;
            $display("FAIL wrap_63: got %08h expected %08h", k_out, exp_v);
        end
        drive(6'd0);
        checks++;
        exp_v = exp_q.pop_front();
        if (k_out !== exp_v) begin
            errors++;
            $display("FAIL wrap_0: got %08h expected %08h", k_out, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 38; i <= 40; i++) begin
            drive(6'(i));
            checks++;
            exp_v = exp_q.pop_front();
            if (k_out !== exp_v) begin
                errors++;
                $display("FAIL midrun addr %0d: got %08h expected %08h", i, k_out, exp_v);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (k_out !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset_async: got %08h expected 00000000", k_out);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        addr = 6'd40;
        exp_q.push_back(k_tab[40]);
        @(posedge clk);
        #1;
        checks++;
        exp_v = exp_q.pop_front();
        if (k_out !== exp_v) begin
            errors++;
            $display("FAIL midrun_first_read: got %08h expected %08h", k_out, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) begin
            drive(6'($urandom_range(63, 0)));
            checks++;
            exp_v = exp_q.pop_front();
            if (k_out !== exp_v) begin
                errors++;
                $display("FAIL random read %0d addr %0d: got %08h expected %08h", i, addr, k_out, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        addr  = 6'd0;
        test_reset();
        test_sweep();
        test_latency();
        test_hold();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
